// File: rtl/csa_tree_pipe_if.sv
// csa_tree_pipe_if: valid/ready bus carrying operand beats into and redundant pairs out of the CSA tree
interface csa_tree_pipe_if #(
  parameter int WIDTH = 64,
  parameter int N_IN = 17
);
  logic in_valid, in_ready, in_acc, out_valid, out_ready;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_sum, out_carry;
  modport master (output in_valid, in_data, in_acc, out_ready, input in_ready, out_valid, out_sum, out_carry);
  modport slave (input in_valid, in_data, in_acc, out_ready, output in_ready, out_valid, out_sum, out_carry);
endinterface

// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe: pipelined 3:2 carry-save reduction of N_IN operands to a sum/carry pair, optional accumulate
module csa_tree_pipe #(
  parameter int WIDTH = 64,
  parameter int N_IN = 17,
  parameter int LVL_PER_STG = 2,
  parameter int ACC_EN = 0
) (
  input logic clk,
  input logic rst,
  input logic flush,
  csa_tree_pipe_if.slave bus
);
  function automatic int cnt(input int l);
    int n = N_IN;
    for (int i = 0; i < l; i++) n = n - n / 3;
    return n;
  endfunction
  function automatic int levels();
    int l = 0;
    while (l < 64 && cnt(l) > 2) l++;
    return l;
  endfunction
  localparam int L = levels();
  if (N_IN < 3 || N_IN > 32) begin : g_bad_n
    $error("csa_tree_pipe: N_IN must be 3..32");
  end
  if (LVL_PER_STG < 1 || LVL_PER_STG > 8) begin : g_bad_l
    $error("csa_tree_pipe: LVL_PER_STG must be 1..8");
  end
  logic adv;
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv && !flush;
  for (genvar l = 0; l <= L; l++) begin : lv
    localparam int N = cnt(l);
    logic [WIDTH-1:0] v [N];
    logic vl, tg;
    if (l == 0) begin : g_in
      for (genvar k = 0; k < N; k++) begin : g_k
        assign v[k] = bus.in_data[k*WIDTH +: WIDTH];
      end
      assign vl = bus.in_valid;
      assign tg = bus.in_acc;
    end else begin : g_csa
      localparam int T = cnt(l - 1) / 3;
      logic [WIDTH-1:0] c [N];
      for (genvar j = 0; j < N; j++) begin : g_j
        if (j >= 2 * T) begin : g_pass
          assign c[j] = lv[l-1].v[j + T];
        end else begin : g_fa
          logic [WIDTH-1:0] a, b, d;
          assign a = lv[l-1].v[3 * (j / 2)];
          assign b = lv[l-1].v[3 * (j / 2) + 1];
          assign d = lv[l-1].v[3 * (j / 2) + 2];
          assign c[j] = (j % 2 == 0) ? a ^ b ^ d : ((a & b) | (a & d) | (b & d)) << 1;
        end
      end
      if (l % LVL_PER_STG == 0 || l == L) begin : g_reg
        always_ff @(posedge clk or posedge rst)
          if (rst) begin
            v <= '{default: '0};
            vl <= 1'b0;
            tg <= 1'b0;
          end else if (flush) vl <= 1'b0;
          else if (adv) begin
            v <= c;
            vl <= lv[l-1].vl;
            tg <= lv[l-1].tg;
          end
      end else begin : g_wire
        assign v = c;
        assign vl = lv[l-1].vl;
        assign tg = lv[l-1].tg;
      end
    end
  end
  if (ACC_EN != 0) begin : g_acc
    logic [WIDTH-1:0] hs, hc, os, oc, ps, pc, s1, k1, ms, mc, t0, t1;
    logic ov, take;
    assign take = bus.out_valid && bus.out_ready;
    assign t0 = lv[L].v[0];
    assign t1 = lv[L].v[1];
    // a pair leaving this very cycle is the one a tagged beat must add
    assign ps = lv[L].tg ? (take ? os : hs) : '0;
    assign pc = lv[L].tg ? (take ? oc : hc) : '0;
    assign s1 = t0 ^ t1 ^ ps;
    assign k1 = ((t0 & t1) | (t0 & ps) | (t1 & ps)) << 1;
    assign ms = s1 ^ k1 ^ pc;
    assign mc = ((s1 & k1) | (s1 & pc) | (k1 & pc)) << 1;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        {os, oc, hs, hc} <= '0;
        ov <= 1'b0;
      end else if (flush) begin
        {hs, hc} <= '0;
        ov <= 1'b0;
      end else begin
        if (take) {hs, hc} <= {os, oc};
        if (adv) begin
          {os, oc} <= {ms, mc};
          ov <= lv[L].vl;
        end
      end
    assign bus.out_sum = os;
    assign bus.out_carry = oc;
    assign bus.out_valid = ov;
  end else begin : g_noacc
    assign bus.out_sum = lv[L].v[0];
    assign bus.out_carry = lv[L].v[1];
    assign bus.out_valid = lv[L].vl;
  end
endmodule

// File: tb/tb_csa_tree_pipe.sv
// tb_csa_tree_pipe: scoreboard bench over three configurations of the CSA tree
module tb_csa_tree_pipe;
  logic clk = 0, rst = 1, flush = 0;
  always #5 clk = ~clk;
  csa_tree_pipe_if #(.WIDTH(64), .N_IN(17)) b0 ();
  csa_tree_pipe_if #(.WIDTH(8), .N_IN(3)) b1 ();
  csa_tree_pipe_if #(.WIDTH(16), .N_IN(17)) b2 ();
  csa_tree_pipe #(.WIDTH(64), .N_IN(17), .LVL_PER_STG(2), .ACC_EN(0)) u0 (.clk(clk), .rst(rst), .flush(flush), .bus(b0.slave));
  csa_tree_pipe #(.WIDTH(8), .N_IN(3), .LVL_PER_STG(1), .ACC_EN(0)) u1 (.clk(clk), .rst(rst), .flush(flush), .bus(b1.slave));
  csa_tree_pipe #(.WIDTH(16), .N_IN(17), .LVL_PER_STG(3), .ACC_EN(1)) u2 (.clk(clk), .rst(rst), .flush(flush), .bus(b2.slave));
  int tests = 0, fails = 0, cyc = 0;
  bit pat = 0;
  logic [63:0] q0[$];
  logic [7:0] q1[$];
  logic [15:0] q2[$];
  logic [15:0] last2 = 0;
  logic [1087:0] d0;
  logic [271:0] d2;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic ov(input int w);
    return w == 0 ? b0.out_valid : w == 1 ? b1.out_valid : b2.out_valid;
  endfunction
  function automatic int qs(input int w);
    return w == 0 ? q0.size() : w == 1 ? q1.size() : q2.size();
  endfunction
  task automatic lat(input int w, input int d);
    int n = 1;
    while (!ov(w) && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, d);
  endtask
  task automatic drain(input int w);
    for (int i = 0; i < 60 && qs(w) != 0; i++) @(posedge clk);
    chk("drain", qs(w), 0);
  endtask
  task automatic send0(input logic [1087:0] d);
    logic [63:0] s = 0;
    b0.in_data = d;
    b0.in_valid = 1;
    @(negedge clk);
    for (int i = 0; i < 50 && !b0.in_ready; i++) @(negedge clk);
    chk("accept0", b0.in_ready, 1);
    for (int k = 0; k < 17; k++) s += d[k*64 +: 64];
    if (b0.in_ready) q0.push_back(s);
    @(posedge clk);
    #1 b0.in_valid = 0;
  endtask
  task automatic send1(input logic [23:0] d);
    logic [7:0] s = 0;
    b1.in_data = d;
    b1.in_valid = 1;
    @(negedge clk);
    for (int i = 0; i < 50 && !b1.in_ready; i++) @(negedge clk);
    chk("accept1", b1.in_ready, 1);
    for (int k = 0; k < 3; k++) s += d[k*8 +: 8];
    if (b1.in_ready) q1.push_back(s);
    @(posedge clk);
    #1 b1.in_valid = 0;
  endtask
  task automatic send2(input logic [271:0] d, input logic tag);
    logic [15:0] s = 0;
    b2.in_data = d;
    b2.in_acc = tag;
    b2.in_valid = 1;
    @(negedge clk);
    for (int i = 0; i < 50 && !b2.in_ready; i++) @(negedge clk);
    chk("accept2", b2.in_ready, 1);
    for (int k = 0; k < 17; k++) s += d[k*16 +: 16];
    if (tag) s += last2;
    last2 = s;
    if (b2.in_ready) q2.push_back(s);
    @(posedge clk);
    #1 b2.in_valid = 0;
  endtask
  always @(negedge clk) if (!rst) begin
    chk("ready0", b0.in_ready, (!b0.out_valid || b0.out_ready) && !flush);
    chk("ready2", b2.in_ready, (!b2.out_valid || b2.out_ready) && !flush);
    if (b0.out_valid && b0.out_ready) begin
      chk("pending0", q0.size() > 0, 1);
      if (q0.size() > 0) chk("result0", b0.out_sum + b0.out_carry, q0.pop_front());
    end
    if (b1.out_valid && b1.out_ready) begin
      chk("pending1", q1.size() > 0, 1);
      if (q1.size() > 0) chk("result1", 8'(b1.out_sum + b1.out_carry), q1.pop_front());
    end
    if (b2.out_valid && b2.out_ready) begin
      chk("pending2", q2.size() > 0, 1);
      if (q2.size() > 0) chk("result2", 16'(b2.out_sum + b2.out_carry), q2.pop_front());
    end
  end
  always @(posedge clk) if (pat) begin
    cyc++;
    #1 b0.out_ready = (cyc % 4 == 1) || (cyc % 4 == 0);
  end
  initial begin
    {b0.in_valid, b0.in_acc, b1.in_valid, b1.in_acc, b2.in_valid, b2.in_acc} = '0;
    b0.in_data = '0;
    b1.in_data = '0;
    b2.in_data = '0;
    {b0.out_ready, b1.out_ready, b2.out_ready} = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid0", b0.out_valid, 0);
    chk("rst_sum0", b0.out_sum, 0);
    chk("rst_carry0", b0.out_carry, 0);
    chk("rst_valid1", b1.out_valid, 0);
    chk("rst_valid2", b2.out_valid, 0);
    chk("rst_sum2", b2.out_sum, 0);
    rst = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 17; k++) d0[k*64 +: 64] = 64'(k + 1);
    send0(d0);
    lat(0, 3);
    chk("sum153", b0.out_sum + b0.out_carry, 153);
    @(posedge clk);
    #1 chk("one_cycle", b0.out_valid, 0);
    send1({8'h02, 8'hFF, 8'hFF});
    lat(1, 1);
    chk("small_sum", b1.out_sum, 8'h02);
    chk("small_carry", b1.out_carry, 8'hFE);
    @(posedge clk);
    #1;
    pat = 1;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 17; k++) d0[k*64 +: 64] = {$urandom, $urandom};
      send0(d0);
    end
    drain(0);
    pat = 0;
    @(posedge clk);
    #2 b0.out_ready = 1;
    for (int k = 0; k < 17; k++) d2[k*16 +: 16] = 16'd1;
    send2(d2, 0);
    for (int k = 0; k < 17; k++) d2[k*16 +: 16] = 16'd2;
    send2(d2, 1);
    chk("model_acc", last2, 51);
    drain(2);
    for (int k = 0; k < 17; k++) d2[k*16 +: 16] = 16'(k);
    send2(d2, 1);
    send2(d2, 0);
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    q2.delete();
    last2 = 0;
    for (int i = 0; i < 4; i++) begin
      chk("flushed_valid", b2.out_valid, 0);
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 17; k++) d2[k*16 +: 16] = 16'd1;
    send2(d2, 1);
    lat(2, 3);
    chk("acc_cleared", 16'(b2.out_sum + b2.out_carry), 17);
    @(posedge clk);
    #1 b0.out_ready = 0;
    b0.in_valid = 1;
    repeat (5) @(posedge clk);
    #3 chk("stalled_valid", b0.out_valid, 1);
    rst = 1;
    #1 chk("async_valid", b0.out_valid, 0);
    chk("async_sum", b0.out_sum, 0);
    b0.in_valid = 0;
    @(negedge clk);
    rst = 0;
    b0.out_ready = 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 17; k++) d0[k*64 +: 64] = 64'(3 * k);
    send0(d0);
    lat(0, 3);
    chk("post_rst", b0.out_sum + b0.out_carry, 408);
    drain(0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/csa_tree_pipe.md
Name: csa_tree_pipe

Overview:
- Parametrised, pipelined carry-save reduction tree: N_IN operands of WIDTH bits in, one redundant sum/carry pair out.
- Successor to the fixed 17-operand combinational tree. Adds configurable operand count, configurable pipeline register placement, valid/ready flow control, flush, and an optional accumulate mode.
- Sits between the partial-product generator and the final carry-propagate adder in the mul/div unit.

Parameters:
- WIDTH, 64, operand and result width in bits; all arithmetic is modulo 2^WIDTH.
- N_IN, 17, number of input operands; legal range 3..32.
- LVL_PER_STG, 2, CSA levels between pipeline registers; legal range 1..8.
- ACC_EN, 0, 1 = build the accumulate stage and honour in_acc; 0 = in_acc ignored.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- flush, input, 1, synchronous kill of all in-flight beats and the accumulator.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, tree can accept a beat.
- in_data, input, N_IN*WIDTH, operand k at bits [k*WIDTH +: WIDTH].
- in_acc, input, 1, beat is added to the previous accepted output pair (ACC_EN=1 only).
- out_valid, output, 1, result pair valid.
- out_ready, input, 1, downstream accepts the result.
- out_sum, output, WIDTH, redundant sum.
- out_carry, output, WIDTH, redundant carry, already shifted left by 1.

Behaviour:
- Levels: L = number of 3:2 levels to reduce N_IN to 2, where each level maps n -> n - floor(n/3). Examples: N_IN=17 gives L=6; N_IN=3 gives L=1.
- Grouping within a level: operands grouped in index order in triples. Leftovers (n mod 3) pass through unchanged. Every carry vector is shifted left 1 with bit 0 = 0 and the MSB dropped.
- Pipelining: register after every LVL_PER_STG levels and always after the last level. Depth D = ceil(L / LVL_PER_STG) when ACC_EN=0.
- Accumulate stage: when ACC_EN=1, one extra registered 4:2 stage (two CSA levels) adds the held output pair, giving D+1 stages.
- Latency: a beat accepted at edge t is visible on out_* after edge t+D (or t+D+1 with ACC_EN=1), unless stalled.
- Flow control: global advance = !out_valid || out_ready.
  - in_ready = advance, combinational.
  - On advance, every stage register loads from the previous stage; the valid bit travels with each stage. The in_acc tag also travels with the beat.
  - With no advance, all stages hold.
  - Bubbles are compressed only by the global rule; no per-stage skid.
- Accumulator, ACC_EN=1:
  - The held pair is the last pair presented with out_valid && out_ready.
  - Beat with tag=0: final stage output = tree pair + {0,0}.
  - Beat with tag=1: final stage output = tree pair + held pair.
  - Held pair resets to 0 and is cleared by flush.
  - A tag=1 beat that follows a pair not yet consumed still uses the pair being consumed in the same cycle. The global stall guarantees that pair exists.
- Invariant: out_sum + out_carry mod 2^WIDTH = sum of operands mod 2^WIDTH, plus the held pair when tag=1.
- Reset: all valid bits 0, out_valid=0, out_sum=0, out_carry=0, held pair=0. Data registers are also reset to 0. Reset mid-operation discards all beats.
- flush:
  - Next edge clears all valid bits and the held pair.
  - A beat offered in the flush cycle is not accepted; in_ready is forced 0 while flush=1.
  - flush has priority over advance.
- Simultaneous events: out_valid && out_ready together with in_valid moves the pipe by one; full throughput is 1 beat/cycle.
- out_* are driven only from registers; no combinational path from in_data to out_*.
- Parameter check: out-of-range N_IN or LVL_PER_STG triggers an elaboration-time $error.

Test Plan:
- Defaults, in_data = operand k set to k+1 (k=0..16), out_ready=1 -> after 3 cycles (L=6, D=3) out_sum + out_carry = 153, out_valid high for exactly 1 cycle.
- N_IN=3, LVL_PER_STG=1, WIDTH=8, operands 0xFF,0xFF,0x02 -> D=1; sum mod 256 = 0x00 and the dropped carry MSB is verified.
- Back-to-back 20 random beats, out_ready toggling 1,0,0,1 pattern -> every result matches a golden model, in order, no duplicates; in_ready = !out_valid || out_ready every cycle.
- ACC_EN=1, beat A = all operands 1 (tag 0), then beat B = all operands 2 (tag 1) -> outputs 17 then 51 (17+34).
- Beats in flight on stages 1 and 2 with flush=1 for one cycle -> out_valid stays 0; the next tag=1 beat of all 1s yields 17, proving the accumulator was cleared.
- rst asserted asynchronously mid-stream -> out_valid and out_sum drop to 0 before the next edge; the first beat after release yields the correct result with latency D.
